stopwatch_ctrl: RTL and testbench

//  Run/pause/clear controller sitting directly downstream of the 1 s tick timer.

---
 rtl/stopwatch_ctrl.sv | 119 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear controller counting 1 s timer ticks 0..MAX_CNT
// Optional feature macro: STOPWATCH_SEG_EN adds the registered 7-segment output seg.
// Ports:
//   clk        system clock
//   n_rst      asynchronous, active-low reset
//   btn_start  raw start/pause push-button, active-high, asynchronous to clk
//   btn_clear  raw clear push-button, active-high, asynchronous to clk
//   tick       one-cycle pulse from the timer
//   run        timer enable, high only while running
//   count      elapsed ticks, saturating at MAX_CNT
//   done       high once MAX_CNT has been reached
//   seg        active-low {g,f,e,d,c,b,a} hex digit of count (STOPWATCH_SEG_EN only)
module stopwatch_ctrl #(
    parameter logic [3:0]      MAX_CNT      = 4'hF,
    parameter int              DB_W         = 20,
    parameter logic [DB_W-1:0] DEBOUNCE_CYC = 20'd1_000_000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       tick,
    output logic       run,
    output logic [3:0] count,
    output logic       done
`ifdef STOPWATCH_SEG_EN
    ,
    output logic [6:0] seg
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t state, state_n;
    logic [3:0] count_n;
    logic [1:0] btn, sync1, sync2, lvl, lvl_q, flip;
    logic [DB_W-1:0] db_cnt [2];
    logic start_p, clear_p, last;
    // bit 0 = start, bit 1 = clear
    assign btn = {btn_clear, btn_start};
    // the debounced level flips only after DEBOUNCE_CYC consecutive disagreeing samples
    always_comb
        for (int i = 0; i < 2; i++)
            flip[i] = sync2[i] != lvl[i] && db_cnt[i] == DEBOUNCE_CYC - 1'b1;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            sync1  <= '0;
            sync2  <= '0;
            lvl    <= '0;
            lvl_q  <= '0;
            db_cnt <= '{default: '0};
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            lvl   <= lvl ^ flip;
            lvl_q <= lvl;
            for (int i = 0; i < 2; i++)
                db_cnt[i] <= (sync2[i] == lvl[i] || flip[i]) ? '0 : db_cnt[i] + 1'b1;
        end
    assign start_p = lvl[0] & ~lvl_q[0];
    assign clear_p = lvl[1] & ~lvl_q[1];
    assign last    = count == MAX_CNT - 1'b1;
    always_comb begin
        state_n = state;
        count_n = count;
        case (state)
            IDLE: begin
                count_n = '0;
                state_n = start_p ? RUN : IDLE;
            end
            RUN: begin
                // a tick arriving with start_p is still counted; terminal count beats pause
                count_n = tick ? count + 1'b1 : count;
                state_n = (tick && last) ? DONE : start_p ? PAUSE : RUN;
            end
            PAUSE: state_n = start_p ? RUN : PAUSE;
            default: state_n = DONE;
        endcase
        if (clear_p) begin
            state_n = IDLE;
            count_n = '0;
        end
    end
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state <= IDLE;
            count <= '0;
            run   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            run   <= state_n == RUN;
            done  <= state_n == DONE;
        end
`ifdef STOPWATCH_SEG_EN
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) seg <= 7'h40;
        else        seg <= hex7(count);
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: self-checking bench for stopwatch_ctrl (DEBOUNCE_CYC=4, MAX_CNT=3)
module tb_stopwatch_ctrl;
    localparam logic [3:0] MAX = 4'h3;
    localparam int OP_START = 0, OP_CLEAR = 1, OP_TICK = 2;
    logic clk = 1'b0, n_rst = 1'b0, btn_start = 1'b0, btn_clear = 1'b0, tick = 1'b0;
    logic run, done;
    logic [3:0] count;
`ifdef STOPWATCH_SEG_EN
    logic [6:0] seg;
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`endif
    int checks = 0, errors = 0;
    bit m_run, m_done;
    int m_cnt;
    typedef struct {
        int         op;
        logic       er;
        logic [3:0] ec;
        logic       ed;
    } vec_t;
    vec_t tbl [15];

    always #5 clk = ~clk;

    stopwatch_ctrl #(.MAX_CNT(MAX), .DB_W(20), .DEBOUNCE_CYC(20'd4)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .tick(tick),
        .run(run),
        .count(count),
        .done(done)
`ifdef STOPWATCH_SEG_EN
        ,
        .seg(seg)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic check(input string name, input logic er, input logic [3:0] ec, input logic ed,
                         input bit with_seg);
        checks++;
        if (run !== er || count !== ec || done !== ed) begin
            errors++;
            $display("FAIL %s: got run=%b count=%0d done=%b, expected run=%b count=%0d done=%b",
                     name, run, count, done, er, ec, ed);
        end
`ifdef STOPWATCH_SEG_EN
        if (with_seg) begin
            checks++;
            if (seg !== seg_tab[ec]) begin
                errors++;
                $display("FAIL %s seg: got %h expected %h", name, seg, seg_tab[ec]);
            end
        end
`else
        if (with_seg) ;
`endif
    endtask

    task automatic press(input int which);
        if (which == OP_START) btn_start = 1'b1;
        else btn_clear = 1'b1;
        idle(10);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        idle(10);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_op(input int op);
        if (op == OP_TICK) pulse_tick();
        else press(op);
        idle(2);
    endtask

    // Reference: start toggles running unless finished; clear zeroes all; ticks count only while running.
    task automatic model(input int op);
        if (op == OP_START) begin
            if (!m_done) m_run = !m_run;
        end else if (op == OP_CLEAR) begin
            m_run = 0;
            m_done = 0;
            m_cnt = 0;
        end else if (m_run) begin
            m_cnt++;
            if (m_cnt == int'(MAX)) begin
                m_run = 0;
                m_done = 1;
            end
        end
    endtask

    // buttons pressed together and a tick placed on the exact cycle the FSM sees the pulses
    task automatic press_with_tick(input string name, input logic s, input logic c, input logic t,
                                   input logic er, input logic [3:0] ec, input logic ed);
        btn_start = s;
        btn_clear = c;
        idle(6);
        tick = t;
        step();
        tick = 1'b0;
        check(name, er, ec, ed, 1'b0);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        idle(10);
    endtask

    initial begin
        tbl[0]  = '{OP_START, 1'b1, 4'd0, 1'b0};
        tbl[1]  = '{OP_TICK,  1'b1, 4'd1, 1'b0};
        tbl[2]  = '{OP_TICK,  1'b1, 4'd2, 1'b0};
        tbl[3]  = '{OP_TICK,  1'b0, 4'd3, 1'b1};
        tbl[4]  = '{OP_START, 1'b0, 4'd3, 1'b1};
        tbl[5]  = '{OP_TICK,  1'b0, 4'd3, 1'b1};
        tbl[6]  = '{OP_CLEAR, 1'b0, 4'd0, 1'b0};
        tbl[7]  = '{OP_TICK,  1'b0, 4'd0, 1'b0};
        tbl[8]  = '{OP_START, 1'b1, 4'd0, 1'b0};
        tbl[9]  = '{OP_TICK,  1'b1, 4'd1, 1'b0};
        tbl[10] = '{OP_START, 1'b0, 4'd1, 1'b0};
        tbl[11] = '{OP_TICK,  1'b0, 4'd1, 1'b0};
        tbl[12] = '{OP_START, 1'b1, 4'd1, 1'b0};
        tbl[13] = '{OP_TICK,  1'b1, 4'd2, 1'b0};
        tbl[14] = '{OP_CLEAR, 1'b0, 4'd0, 1'b0};

        btn_start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick = i[0];
            step();
        end
        tick = 1'b0;
        btn_start = 1'b0;
        check("reset_hold", 1'b0, 4'd0, 1'b0, 1'b1);
        n_rst = 1'b1;
        idle(12);
        check("after_reset", 1'b0, 4'd0, 1'b0, 1'b1);

        foreach (tbl[i]) begin
            do_op(tbl[i].op);
            check($sformatf("vec%0d", i), tbl[i].er, tbl[i].ec, tbl[i].ed, 1'b1);
        end

        do_op(OP_START);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("tick_latency", 1'b1, 4'd1, 1'b0, 1'b0);
        do_op(OP_TICK);
        check("pre_async", 1'b1, 4'd2, 1'b0, 1'b1);
        @(posedge clk);
        #3 n_rst = 1'b0;
        #1 check("async_reset", 1'b0, 4'd0, 1'b0, 1'b1);
        idle(2);
        n_rst = 1'b1;
        idle(2);

        for (int i = 0; i < 10; i++) begin
            btn_start = (i % 2 == 0);
            idle(2);
        end
        btn_start = 1'b0;
        idle(12);
        check("bounce", 1'b0, 4'd0, 1'b0, 1'b1);
        do_op(OP_START);
        check("after_bounce", 1'b1, 4'd0, 1'b0, 1'b1);
        do_op(OP_TICK);
        do_op(OP_TICK);
        press_with_tick("clear_prio", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        check("clear_prio_hold", 1'b0, 4'd0, 1'b0, 1'b1);

        do_op(OP_START);
        do_op(OP_TICK);
        press_with_tick("tick_start", 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
        do_op(OP_TICK);
        check("paused_tick", 1'b0, 4'd2, 1'b0, 1'b1);
        do_op(OP_START);
        check("resume", 1'b1, 4'd2, 1'b0, 1'b1);
        do_op(OP_CLEAR);

        do_op(OP_START);
        do_op(OP_TICK);
        do_op(OP_TICK);
        press_with_tick("tick_start_term", 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1);
        do_op(OP_CLEAR);
        check("clear_done", 1'b0, 4'd0, 1'b0, 1'b1);

        model(OP_CLEAR);
        for (int i = 0; i < 60; i++) begin
            int r, op;
            r = int'($urandom_range(0, 9));
            op = r < 5 ? OP_TICK : r < 8 ? OP_START : OP_CLEAR;
            do_op(op);
            model(op);
            check($sformatf("rand%0d", i), m_run, 4'(m_cnt), m_done, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
